// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared constants and types for the 4-tap FIR filter and its coefficient
// loader.
//   NTAPS / CW     : coefficients per set and width of one coefficient
//   COEF_BITS      : length of the filter's coefficient scan chain
//   loader_state_t : coefficient loader FSM states
//   coef_set_t     : one coefficient set, element [0] is c0
// -----------------------------------------------------------------------------
package fir_pkg;

    localparam int NTAPS     = 4;
    localparam int CW        = 8;
    localparam int COEF_BITS = NTAPS * CW;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        DONE
    } loader_state_t;

    typedef logic [NTAPS-1:0][CW-1:0] coef_set_t;

endpackage

// File: rtl/fir_coef_loader_if.sv
// -----------------------------------------------------------------------------
// fir_coef_loader_if
// Valid/ready handshake carrying one parallel coefficient set into the loader.
//   coef_in    : packed set {c3,c2,c1,c0}, c0 in the low CW bits
//   coef_valid : source offers a set
//   coef_ready : loader accepts a set this cycle
// Modports: master = coefficient source, slave = loader.
// -----------------------------------------------------------------------------
interface fir_coef_loader_if #(
    parameter int NTAPS = fir_pkg::NTAPS,
    parameter int CW    = fir_pkg::CW
);

    logic [NTAPS*CW-1:0] coef_in;
    logic                coef_valid;
    logic                coef_ready;

    modport master (
        output coef_in,
        output coef_valid,
        input  coef_ready
    );

    modport slave (
        input  coef_in,
        input  coef_valid,
        output coef_ready
    );

endinterface

// File: rtl/fir_piso_shreg.sv
// -----------------------------------------------------------------------------
// fir_piso_shreg
// Parallel-in, serial-out register. A load captures din; a shift moves the
// contents one place towards the MSB, filling with zero. msb is the serial
// output straight from the flop, so it carries no combinational path.
//   ph1   : clock (rising edge)
//   reset : asynchronous active-low reset, clears the register
//   load  : capture din (wins over shift)
//   shift : shift left by one
//   din   : parallel data
//   msb   : current most significant bit
// -----------------------------------------------------------------------------
module fir_piso_shreg #(
    parameter int W = fir_pkg::COEF_BITS
) (
    input  logic         ph1,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[W-2:0], 1'b0};
        end
    end

    assign msb = q[W-1];

endmodule

// File: rtl/fir_coef_loader.sv
// -----------------------------------------------------------------------------
// fir_coef_loader
// Accepts a full coefficient set over a valid/ready handshake and shifts it,
// MSB first, into the FIR filter's scan chain. Each bit gets a SETUP cycle
// (shiftIn settles, scan clock idle) followed by a PULSE cycle (scan clock
// enabled, shiftIn held), so data is stable a full cycle before every scan
// clock and the enable is never high two cycles running.
//   ph1         : sole clock
//   reset       : asynchronous active-low reset, aborts any load in flight
//   cif         : coefficient handshake (slave side)
//   shiftIn     : serial scan data to the filter
//   shiftClkEn  : scan clock enable, one high cycle per bit
//   busy        : a set is being shifted
//   done        : one-cycle pulse after the last bit is clocked
//   coef_loaded : a complete set sits in the filter
// -----------------------------------------------------------------------------
module fir_coef_loader
    import fir_pkg::*;
#(
    parameter int NTAPS = fir_pkg::NTAPS,
    parameter int CW    = fir_pkg::CW
) (
    input  logic                   ph1,
    input  logic                   reset,
    fir_coef_loader_if.slave       cif,
    output logic                   shiftIn,
    output logic                   shiftClkEn,
    output logic                   busy,
    output logic                   done,
    output logic                   coef_loaded
);

    localparam int NBITS = NTAPS * CW;
    // One spare bit so the counter cannot wrap inside a load.
    localparam int CNT_W = $clog2(NBITS) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);

    loader_state_t    state;
    logic [CNT_W-1:0] bit_cnt;
    logic             ready_q;
    logic             xfer;

    // ready_q is high exactly in IDLE and DONE, so a transfer can only
    // start from those states.
    assign xfer           = cif.coef_valid & ready_q;
    assign cif.coef_ready = ready_q;

    // shiftIn comes straight from the shift-register flop: loaded on the
    // transfer edge, advanced only as PULSE exits, so it is steady through
    // each SETUP/PULSE pair.
    fir_piso_shreg #(
        .W(NBITS)
    ) u_shreg (
        .ph1   (ph1),
        .reset (reset),
        .load  (xfer),
        .shift (state == PULSE),
        .din   (cif.coef_in),
        .msb   (shiftIn)
    );

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            ready_q     <= 1'b1;
            shiftClkEn  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            coef_loaded <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (xfer) begin
                        state       <= SETUP;
                        bit_cnt     <= '0;
                        ready_q     <= 1'b0;
                        busy        <= 1'b1;
                        coef_loaded <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                SETUP: begin
                    state      <= PULSE;
                    shiftClkEn <= 1'b1;
                end
                PULSE: begin
                    shiftClkEn <= 1'b0;
                    bit_cnt    <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state       <= DONE;
                        ready_q     <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        coef_loaded <= 1'b1;
                    end else begin
                        state <= SETUP;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coef_loader.sv
// -----------------------------------------------------------------------------
// tb_fir_coef_loader
// Directed bench for fir_coef_loader. Inputs are driven 1 ns after the rising
// edge. A monitor on the falling edge models the filter's scan chain, counts
// scan pulses, transfers and done pulses, and flags any scan-clock setup or
// back-to-back enable violation.
// -----------------------------------------------------------------------------
module tb_fir_coef_loader;

    import fir_pkg::*;

    logic ph1   = 1'b0;
    logic reset = 1'b0;
    logic shiftIn, shiftClkEn, busy, done, coef_loaded;

    always #5 ph1 = ~ph1;

    fir_coef_loader_if cif ();

    fir_coef_loader dut (
        .ph1         (ph1),
        .reset       (reset),
        .cif         (cif),
        .shiftIn     (shiftIn),
        .shiftClkEn  (shiftClkEn),
        .busy        (busy),
        .done        (done),
        .coef_loaded (coef_loaded)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- falling-edge monitor / filter scan-chain model ----------
    int          cyc        = 0;
    int          pulse_cnt  = 0;
    int          xfer_cnt   = 0;
    int          done_cnt   = 0;
    int          setup_viol = 0;
    logic [63:0] stream     = '0;
    logic [31:0] chain      = '0;
    logic        prev_en    = 1'b0;
    logic        prev_in    = 1'b0;

    always @(negedge ph1) begin
        if (reset) begin
            if (shiftClkEn && prev_en) begin
                setup_viol++;
                $display("FAIL clk_en_consecutive: shiftClkEn=1 in two adjacent cycles at cycle %0d, required isolated pulses", cyc);
            end
            if (shiftClkEn && !prev_en && shiftIn !== prev_in) begin
                setup_viol++;
                $display("FAIL shift_setup: shiftIn=%b at scan pulse, prior cycle %b, required equal (cycle %0d)", shiftIn, prev_in, cyc);
            end
            if (shiftClkEn) begin
                pulse_cnt++;
                stream = {stream[62:0], shiftIn};
                chain  = {chain[30:0], shiftIn};
            end
            if (cif.coef_valid && cif.coef_ready) xfer_cnt++;
            if (done) done_cnt++;
            prev_en = shiftClkEn;
            prev_in = shiftIn;
        end else begin
            prev_en = 1'b0;
            prev_in = shiftIn;
        end
        cyc++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    // Offers v and waits for the transfer; xc is the transfer cycle.
    // With hold=1 coef_valid stays asserted afterwards.
    task automatic load(input logic [31:0] v, input bit hold, output int xc);
        int n;
        n = 0;
        cif.coef_in    = v;
        cif.coef_valid = 1'b1;
        while (cif.coef_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        n_assert++;
        if (cif.coef_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_ready_timeout: coef_ready=%b after %0d cycles, required 1", cif.coef_ready, n);
        end
        xc = cyc;
        tick();
        if (!hold) cif.coef_valid = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        n_assert++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, n);
        end
        dc = cyc;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset          = 1'b0;
        cif.coef_valid = 1'b0;
        cif.coef_in    = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        n_assert++; if (cif.coef_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", cif.coef_ready); end
        n_assert++; if (busy !== 1'b0)           begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_assert++; if (shiftClkEn !== 1'b0)     begin n_fail++; $display("FAIL reset_clk_en: got %b, required 0", shiftClkEn); end
        n_assert++; if (shiftIn !== 1'b0)        begin n_fail++; $display("FAIL reset_shift_in: got %b, required 0", shiftIn); end
        n_assert++; if (coef_loaded !== 1'b0)    begin n_fail++; $display("FAIL reset_loaded: got %b, required 0", coef_loaded); end
        n_assert++; if (done !== 1'b0)           begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
    endtask

    task automatic test_single_load();
        int        p0, xc, dc, y;
        coef_set_t taps;
        p0 = pulse_cnt;
        load(32'h0302_0104, 1'b0, xc);
        n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b, required 1", busy); end
        n_assert++; if (coef_loaded !== 1'b0) begin n_fail++; $display("FAIL single_loaded_cleared: got %b, required 0", coef_loaded); end
        wait_done(dc);
        n_assert++; if (dc - xc != 65) begin n_fail++; $display("FAIL single_latency: got %0d cycles, required 65", dc - xc); end
        n_assert++; if (pulse_cnt - p0 != 32) begin n_fail++; $display("FAIL single_pulses: got %0d, required 32", pulse_cnt - p0); end
        n_assert++; if (stream[31:0] !== 32'h0302_0104) begin n_fail++; $display("FAIL single_stream: got %h, required 03020104", stream[31:0]); end
        n_assert++; if (coef_loaded !== 1'b1) begin n_fail++; $display("FAIL single_loaded: got %b, required 1", coef_loaded); end
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_done: got %b, required 0", busy); end
        taps = chain;
        n_assert++;
        if (taps[0] !== 8'd4 || taps[1] !== 8'd1 || taps[2] !== 8'd2 || taps[3] !== 8'd3) begin
            n_fail++;
            $display("FAIL single_taps: got c0..c3=%0d,%0d,%0d,%0d, required 4,1,2,3", taps[0], taps[1], taps[2], taps[3]);
        end
        // Filter with a=10 held on every tap.
        y = 10 * (int'(taps[0]) + int'(taps[1]) + int'(taps[2]) + int'(taps[3]));
        n_assert++; if (y != 100) begin n_fail++; $display("FAIL single_filter_y: got %0d, required 100", y); end
        tick();
        n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got %b one cycle later, required 0", done); end
        n_assert++; if (coef_loaded !== 1'b1 || cif.coef_ready !== 1'b1) begin
            n_fail++; $display("FAIL single_idle: coef_loaded=%b coef_ready=%b, required 1 1", coef_loaded, cif.coef_ready);
        end
    endtask

    task automatic test_valid_while_busy();
        int xc, dc, xf0;
        bit ready_seen;
        load(32'h1234_5678, 1'b0, xc);
        repeat (4) tick();
        n_assert++; if (cyc - xc != 5) begin n_fail++; $display("FAIL busy_align: at cycle offset %0d, required 5", cyc - xc); end
        cif.coef_in    = 32'hFFFF_FFFF;
        cif.coef_valid = 1'b1;
        xf0        = xfer_cnt;
        ready_seen = 1'b0;
        for (int i = 5; i <= 40; i++) begin
            if (cif.coef_ready !== 1'b0) ready_seen = 1'b1;
            tick();
        end
        cif.coef_valid = 1'b0;
        n_assert++; if (ready_seen) begin n_fail++; $display("FAIL busy_ready: coef_ready went high during load, required 0"); end
        n_assert++; if (xfer_cnt != xf0) begin n_fail++; $display("FAIL busy_xfer: got %0d transfers, required 0", xfer_cnt - xf0); end
        wait_done(dc);
        n_assert++; if (dc - xc != 65) begin n_fail++; $display("FAIL busy_latency: got %0d cycles, required 65", dc - xc); end
        n_assert++; if (stream[31:0] !== 32'h1234_5678) begin n_fail++; $display("FAIL busy_stream: got %h, required 12345678", stream[31:0]); end
        load(32'hFFFF_FFFF, 1'b0, xc);
        wait_done(dc);
        n_assert++; if (stream[31:0] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL busy_second_stream: got %h, required ffffffff", stream[31:0]); end
    endtask

    task automatic test_back_to_back();
        int p0, xc, d1, d2, xf;
        p0 = pulse_cnt;
        load(32'hC3C3_3CC3, 1'b1, xc);
        cif.coef_in = 32'hA5A5_5AA5;
        wait_done(d1);
        n_assert++; if (d1 - xc != 65) begin n_fail++; $display("FAIL b2b_latency1: got %0d cycles, required 65", d1 - xc); end
        n_assert++; if (stream[31:0] !== 32'hC3C3_3CC3) begin n_fail++; $display("FAIL b2b_stream1: got %h, required c3c33cc3", stream[31:0]); end
        n_assert++; if (cif.coef_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_done: got %b, required 1", cif.coef_ready); end
        xf = xfer_cnt;
        tick();
        cif.coef_valid = 1'b0;
        n_assert++; if (xfer_cnt != xf + 1) begin n_fail++; $display("FAIL b2b_xfer_on_done: got %0d transfers, required 1", xfer_cnt - xf); end
        n_assert++; if (busy !== 1'b1 || coef_loaded !== 1'b0) begin
            n_fail++; $display("FAIL b2b_no_idle: busy=%b coef_loaded=%b, required 1 0", busy, coef_loaded);
        end
        wait_done(d2);
        n_assert++; if (d2 - d1 != 65) begin n_fail++; $display("FAIL b2b_done_gap: got %0d cycles, required 65", d2 - d1); end
        n_assert++; if (pulse_cnt - p0 != 64) begin n_fail++; $display("FAIL b2b_pulses: got %0d, required 64", pulse_cnt - p0); end
        n_assert++; if (stream[31:0] !== 32'hA5A5_5AA5) begin n_fail++; $display("FAIL b2b_stream2: got %h, required a5a55aa5", stream[31:0]); end
    endtask

    task automatic test_reset_mid_load();
        int p0, d0, xc, dc, n;
        p0 = pulse_cnt;
        load(32'h5555_AAAA, 1'b0, xc);
        n = 0;
        while (!(shiftClkEn === 1'b1 && pulse_cnt - p0 == 10) && n < 100) begin
            tick();
            n++;
        end
        n_assert++; if (pulse_cnt - p0 != 10 || shiftClkEn !== 1'b1) begin
            n_fail++; $display("FAIL abort_reach: pulses=%0d shiftClkEn=%b, required 10 1", pulse_cnt - p0, shiftClkEn);
        end
        reset = 1'b0;
        #1;
        n_assert++; if (shiftClkEn !== 1'b0) begin n_fail++; $display("FAIL abort_clk_en: got %b, required 0", shiftClkEn); end
        n_assert++; if (busy !== 1'b0 || coef_loaded !== 1'b0 || cif.coef_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_state: busy=%b coef_loaded=%b coef_ready=%b, required 0 0 1", busy, coef_loaded, cif.coef_ready);
        end
        tick();
        tick();
        reset = 1'b1;
        d0 = done_cnt;
        p0 = pulse_cnt;
        repeat (70) tick();
        n_assert++; if (done_cnt != d0 || pulse_cnt != p0 || coef_loaded !== 1'b0) begin
            n_fail++; $display("FAIL abort_quiet: done=%0d pulses=%0d coef_loaded=%b, required 0 0 0", done_cnt - d0, pulse_cnt - p0, coef_loaded);
        end
        load(32'h7F80_0001, 1'b0, xc);
        wait_done(dc);
        n_assert++; if (dc - xc != 65) begin n_fail++; $display("FAIL abort_reload_latency: got %0d cycles, required 65", dc - xc); end
        n_assert++; if (pulse_cnt - p0 != 32) begin n_fail++; $display("FAIL abort_reload_pulses: got %0d, required 32", pulse_cnt - p0); end
        n_assert++; if (stream[31:0] !== 32'h7F80_0001) begin n_fail++; $display("FAIL abort_reload_stream: got %h, required 7f800001", stream[31:0]); end
        n_assert++; if (coef_loaded !== 1'b1) begin n_fail++; $display("FAIL abort_reload_loaded: got %b, required 1", coef_loaded); end
    endtask

    task automatic test_setup_hold();
        n_assert++;
        if (setup_viol != 0) begin
            n_fail++;
            $display("FAIL scan_timing: got %0d violations, required 0", setup_viol);
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_valid_while_busy();
        test_back_to_back();
        test_reset_mid_load();
        test_setup_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
